ingress_pkt_buffer: RTL and testbench
=====================================

INGRESS_PKT_BUFFER -- requirements
Module: ingress_pkt_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_PORTS, 4, number of switch ports.
- IDX_WIDTH, $clog2(N_PORTS), port index width.
- DATA_WIDTH, 8, beat width.
- DEPTH, 16, data beats stored (power of 2, >=2).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  beat from packet filter.
- in_valid  in  1  beat valid.
- in_last  in  1  final beat of packet.
- in_dst  in  IDX_WIDTH  destination port; sampled on first beat only.
- in_ready  out  1  beat accepted (accept = in_valid && in_ready).
- out_data  out  DATA_WIDTH  head beat, first-word-fall-through.
- out_valid  out  1  head beat belongs to a fully stored packet.
- out_last  out  1  head beat is last of its packet.
- out_dst  out  IDX_WIDTH  destination of head packet; stable for the whole packet.
- out_ready  in  1  switch scheduler consumes head beat (pop = out_valid && out_ready).
- pkt_count  out  IDX_WIDTH+$clog2(DEPTH)+1  committed packets held.
- drop_count  out  16  dropped packets, saturating at 16'hFFFF.

Function
REQ-003 Store-and-forward: out_valid SHALL assert only for packets whose last beat has been written; once asserted for a packet it SHALL stay high until that packet's last beat is popped.
REQ-004 Write FSM states SHALL be IDLE (await first beat), RECV (mid-packet), DROP (discard until in_last).
REQ-005 in_ready SHALL be 1 in every state when not in reset; overflow is handled by dropping, never by backpressure.
REQ-006 IDLE, accepted beat: capture in_dst into pending dst; write beat at wr_ptr; in_last=1 -> commit, stay IDLE; else -> RECV.
REQ-007 RECV, accepted beat: write at wr_ptr; in_last=1 -> commit, go IDLE.
REQ-008 Full SHALL be (wr_ptr - rd_ptr) == DEPTH on registered pointers (DEPTH-bit index plus wrap bit); a pop in the same cycle does not relieve full.
REQ-009 Accepted beat while full (IDLE or RECV): rewind wr_ptr to commit_ptr, increment drop_count once, go DROP if in_last=0, else IDLE.
REQ-010 DROP: discard accepted beats; in_last=1 -> IDLE; no further drop_count increment.
REQ-011 Commit: commit_ptr <= wr_ptr+1, push pending dst into dst FIFO, pkt_count+1; out_valid may assert the cycle after commit.
REQ-012 Read side SHALL expose mem[rd_ptr] only while rd_ptr != commit_ptr; pop advances rd_ptr; popping a last beat pops the dst FIFO and decrements pkt_count.
REQ-013 Simultaneous commit and last-beat pop SHALL leave pkt_count unchanged.
REQ-014 A packet of exactly DEPTH beats into an empty buffer SHALL be stored; any longer packet SHALL be dropped.
REQ-015 Pointer arithmetic SHALL wrap modulo 2*DEPTH, with no extra logic at the wrap boundary.

Reset
REQ-016 On reset: FSM=IDLE, all pointers 0, pkt_count=0, drop_count=0, dst FIFO empty; outputs in_ready=0, out_valid=0, out_last=0, out_dst=0, out_data don't-care.
REQ-017 Reset mid-packet or mid-drop SHALL discard all content, including committed packets.

Structure
REQ-018 N_PORTS, IDX_WIDTH and the write-state enum wr_state_t SHALL live in shared package pf_switch_pkg.
REQ-019 Destination queue SHALL be sub-module pkt_dst_fifo (DEPTH entries x IDX_WIDTH, sync reset); it cannot overflow because every packet uses >=1 beat.

Verification
REQ-020 3-beat packet, dst=2, out_ready=1 -> out_valid rises the cycle after in_last; 3 beats out, out_dst=2, out_last on beat 3, pkt_count 1->0.
REQ-021 Two back-to-back packets (dst=1, 2 beats; dst=3, 1 beat), out_ready=0 then 1 -> pkt_count=2; output order preserved, out_dst switches 1->3 after the first last-beat pop.
REQ-022 DEPTH=16 with out_ready=0, send a 20-beat packet -> drop_count=1, pkt_count=0, out_valid=0; a following 4-beat packet is stored and delivered.
REQ-023 Fill with a 16-beat packet, then a 1-beat packet while popping -> second packet dropped (REQ-008), drop_count=1.
REQ-024 Commit of packet B in the same cycle as last-beat pop of packet A -> pkt_count unchanged, out_dst switches to B's destination next cycle.
REQ-025 Assert reset on beat 2 of a 4-beat packet with 1 committed packet held -> next cycle out_valid=0, pkt_count=0; a new packet afterwards is delivered intact.

Source files
------------

// File: rtl/pf_switch_pkg.sv
// Shared switch-wide definitions: port count, port index width and the
// ingress write-side state encoding.
package pf_switch_pkg;

  localparam int N_PORTS   = 4;
  localparam int IDX_WIDTH = $clog2(N_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pkt_dst_fifo.sv
// Destination-port queue: one entry per committed packet, head entry is the
// destination of the packet currently at the head of the beat buffer.
module pkt_dst_fifo #(
  parameter int DEPTH     = 16,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [IDX_WIDTH-1:0] push_dst,
  input  logic                 pop,
  output logic [IDX_WIDTH-1:0] head,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [IDX_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  // Pointer advance; overflow is impossible since each packet holds a beat slot.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless until referenced by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_dst;
  end

endmodule

// File: rtl/ingress_pkt_buffer.sv
// Store-and-forward ingress buffer. Beats are written speculatively and only
// become visible to the scheduler once the packet's last beat is committed;
// packets that do not fit are discarded rather than back-pressured.
module ingress_pkt_buffer
  import pf_switch_pkg::*;
#(
  parameter int N_PORTS    = pf_switch_pkg::N_PORTS,
  parameter int IDX_WIDTH  = $clog2(N_PORTS),
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic [IDX_WIDTH-1:0]                in_dst,
  output logic                                in_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid,
  output logic                                out_last,
  output logic [IDX_WIDTH-1:0]                out_dst,
  input  logic                                out_ready,
  output logic [IDX_WIDTH+$clog2(DEPTH):0]    pkt_count,
  output logic [15:0]                         drop_count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            PW      = AW + 1;
  localparam int            CW      = IDX_WIDTH + AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  wr_state_t            state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [IDX_WIDTH-1:0] pend_dst_q, pend_dst_d;
  logic [CW-1:0]        pkt_count_q, pkt_count_d;
  logic [15:0]          drop_count_q, drop_count_d;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];

  logic                 accept, full, wr_en, commit, pop, pop_last, fifo_empty;
  logic [IDX_WIDTH-1:0] push_dst, fifo_head;

  assign in_ready   = ~reset;
  assign accept     = in_valid & in_ready;
  // Full uses registered pointers only, so a same-cycle pop does not free a slot.
  assign full       = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign out_valid  = (rd_ptr_q != commit_ptr_q);
  assign out_data   = mem_data[rd_ptr_q[AW-1:0]];
  assign out_last   = out_valid & mem_last[rd_ptr_q[AW-1:0]];
  assign out_dst    = fifo_empty ? '0 : fifo_head;
  assign pop        = out_valid & out_ready;
  assign pop_last   = pop & out_last;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

  // Write FSM: accept, commit or discard incoming beats.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    pend_dst_d   = pend_dst_q;
    drop_count_d = drop_count_q;
    push_dst     = pend_dst_q;
    wr_en        = 1'b0;
    commit       = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE, RECV: begin
          if (full) begin
            // Abandon the partial packet: forget every uncommitted beat.
            wr_ptr_d = commit_ptr_q;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
            state_d = in_last ? IDLE : DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (state_q == IDLE) begin
              pend_dst_d = in_dst;
              push_dst   = in_dst;
            end
            if (in_last) begin
              commit       = 1'b1;
              commit_ptr_d = wr_ptr_q + PW'(1);
              state_d      = IDLE;
            end else begin
              state_d = RECV;
            end
          end
        end
        DROP:    if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Read pointer and committed-packet count.
  always_comb begin
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    pkt_count_d = pkt_count_q;
    if (commit && !pop_last)      pkt_count_d = pkt_count_q + CW'(1);
    else if (!commit && pop_last) pkt_count_d = pkt_count_q - CW'(1);
  end

  // Control registers; reset discards everything, committed packets included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Datapath registers: beat storage and the pending destination.
  always_ff @(posedge clk) begin
    pend_dst_q <= pend_dst_d;
    if (wr_en) begin
      mem_data[wr_ptr_q[AW-1:0]] <= in_data;
      mem_last[wr_ptr_q[AW-1:0]] <= in_last;
    end
  end

  pkt_dst_fifo #(
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_dst_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (commit),
    .push_dst (push_dst),
    .pop      (pop_last),
    .head     (fifo_head),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ingress_pkt_buffer.sv
// Bench for ingress_pkt_buffer: directed scenarios followed by random traffic,
// every cycle compared against a packet-level queue model.
module tb_ingress_pkt_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_last, in_ready;
  logic       out_valid, out_last, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] in_dst, out_dst;
  logic [6:0] pkt_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  ingress_pkt_buffer #(
    .N_PORTS    (4),
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_dst     (in_dst),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_dst    (out_dst),
    .out_ready  (out_ready),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: committed beats awaiting delivery, per-packet destinations,
  // and the packet currently arriving.
  logic [7:0] q_data[$];
  bit         q_last[$];
  bit [1:0]   q_dst[$];
  logic [7:0] p_data[$];
  bit [1:0]   p_dst;
  bit         in_pkt, dropping, m_full;
  int         m_drops;

  always @(posedge clk) begin
    if (reset) begin
      q_data.delete(); q_last.delete(); q_dst.delete(); p_data.delete();
      in_pkt = 0; dropping = 0; m_drops = 0;
    end else begin
      m_full = (q_data.size() + p_data.size()) == DEPTH;
      if (q_data.size() > 0 && out_ready) begin
        if (q_last[0]) void'(q_dst.pop_front());
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      if (in_valid) begin
        if (dropping) begin
          if (in_last) dropping = 0;
        end else if (m_full) begin
          p_data.delete();
          in_pkt = 0;
          if (m_drops < 65535) m_drops++;
          dropping = !in_last;
        end else begin
          if (!in_pkt) p_dst = in_dst;
          p_data.push_back(in_data);
          if (in_last) begin
            foreach (p_data[i]) begin
              q_data.push_back(p_data[i]);
              q_last.push_back(i == p_data.size() - 1);
            end
            q_dst.push_back(p_dst);
            p_data.delete();
            in_pkt = 0;
          end else begin
            in_pkt = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",   in_ready,   !reset);
    check("out_valid",  out_valid,  q_data.size() > 0);
    check("out_last",   out_last,   q_data.size() > 0 ? q_last[0] : 1'b0);
    check("out_dst",    out_dst,    q_dst.size() > 0 ? q_dst[0] : 2'd0);
    check("pkt_count",  pkt_count,  q_dst.size());
    check("drop_count", drop_count, m_drops);
    if (q_data.size() > 0) check("out_data", out_data, q_data[0]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input bit l, input bit [1:0] dst, input bit ordy, input bit rst);
    reset     = rst;
    in_valid  = v;
    in_data   = 8'($urandom);
    in_last   = l;
    in_dst    = dst;
    out_ready = ordy;
    tick();
  endtask

  task automatic send(input bit [1:0] dst, input int len, input bit ordy);
    for (int i = 0; i < len; i++) drive(1'b1, i == len - 1, dst, ordy, 1'b0);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, ordy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_dst = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Single 3-beat packet, drained immediately.
    send(2'd2, 3, 1'b1); idle(5, 1'b1);
    // Two packets held, then drained in order.
    send(2'd1, 2, 1'b0); send(2'd3, 1, 1'b0); idle(3, 1'b0); idle(6, 1'b1);
    // Oversized packet dropped, following packet kept.
    send(2'd0, 20, 1'b0); send(2'd1, 4, 1'b0); idle(2, 1'b0); idle(8, 1'b1);
    // Buffer exactly full, then a 1-beat packet while popping is dropped.
    send(2'd2, 16, 1'b0); send(2'd3, 1, 1'b1); idle(20, 1'b1);
    // Commit of B coincides with the last-beat pop of A.
    send(2'd1, 2, 1'b0); idle(1, 1'b0);
    drive(1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    idle(6, 1'b1);
    // Reset on beat 2 of a packet while one packet is committed.
    send(2'd2, 3, 1'b0); idle(1, 1'b0);
    drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
    idle(2, 1'b1); send(2'd3, 4, 1'b1); idle(6, 1'b1);

    // Random traffic with alternating slow and fast drain phases.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit v, l, ordy, rst;
      v    = $urandom_range(0, 9) < 7;
      l    = $urandom_range(0, 5) == 0;
      ordy = (cyc % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      rst  = $urandom_range(0, 599) == 0;
      drive(v, l, 2'($urandom), ordy, rst);
    end
    idle(40, 1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
